// File: rtl/spi_ram_pkg.sv
// Shared command encodings, controller states and command decode for the SPI RAM burst block.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD0,
    CMD1,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_DATA,
    HOLD
  } state_e;

  function automatic state_e decode_cmd(input logic [1:0] cmd);
    case (cmd)
      CMD_WR_ADDR: return WR_ADDR;
      CMD_WR_DATA: return WR_DATA;
      CMD_RD_ADDR: return RD_ADDR;
      default:     return RD_DATA;
    endcase
  endfunction

endpackage

// File: rtl/spi_ram_burst_if.sv
// SPI pin bundle: the master drives select and MOSI, the slave returns MISO and the frame error pulse.
interface spi_ram_burst_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic frame_err;

  modport master (output SS_n, output MOSI, input MISO, input frame_err);
  modport slave  (input SS_n, input MOSI, output MISO, output frame_err);
endinterface

// File: rtl/spi_ram_mem.sv
// Single-port RAM: synchronous write, registered read, one shared address; contents survive reset.
module spi_ram_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave front-end to a single-port RAM with auto-incrementing write/read pointers and
// gapless burst reads (next word fetched one bit-time before the current word runs out).
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_burst_if.slave spi
);

  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_PREV = CNT_W'(DATA_W - 2);

  state_e            state_q, state_d;
  state_e            cmd_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-2:0]   in_sh_q, in_sh_d;
  logic [SH_W-1:0]   sh_next;
  logic [DATA_W-1:0] out_sh_q, out_sh_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              frame_err_q, frame_err_d;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  assign sh_next   = {in_sh_q, spi.MOSI};
  assign cmd_state = decode_cmd({in_sh_q[0], spi.MOSI});
  assign mem_wdata = sh_next[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_sh_q     <= '0;
      out_sh_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_sh_q     <= in_sh_d;
      out_sh_q    <= out_sh_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_sh_d     = in_sh_q;
    out_sh_d    = out_sh_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_err_d = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = wr_ptr_q;

    if (state_q != IDLE && spi.SS_n) begin
      // Frame closed: drop any partial field; only a half-received write word or address is an error.
      state_d     = IDLE;
      cnt_d       = '0;
      in_sh_d     = '0;
      out_sh_d    = '0;
      frame_err_d = (state_q == WR_ADDR || state_q == RD_ADDR || state_q == WR_DATA)
                    && (cnt_q != '0);
    end else begin
      case (state_q)
        IDLE: begin
          if (!spi.SS_n) begin
            state_d = CMD0;
            cnt_d   = '0;
          end
        end
        CMD0: begin
          in_sh_d = sh_next[SH_W-2:0];
          state_d = CMD1;
        end
        CMD1: begin
          state_d = cmd_state;
          in_sh_d = '0;
          cnt_d   = '0;
          if (cmd_state == RD_DATA) begin
            // Prime the pipeline; the counter pretends a word just finished so E3 loads.
            mem_re   = 1'b1;
            mem_addr = rd_ptr_q;
            cnt_d    = DATA_LAST;
          end
        end
        WR_ADDR, RD_ADDR: begin
          in_sh_d = sh_next[SH_W-2:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            if (state_q == WR_ADDR) begin
              wr_ptr_d = sh_next[ADDR_W-1:0];
            end else begin
              rd_ptr_d = sh_next[ADDR_W-1:0];
            end
            state_d = HOLD;
            cnt_d   = '0;
            in_sh_d = '0;
          end
        end
        WR_DATA: begin
          in_sh_d = sh_next[SH_W-2:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) begin
            mem_we   = 1'b1;
            mem_addr = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = '0;
            in_sh_d  = '0;
          end
        end
        RD_DATA: begin
          if (cnt_q == DATA_LAST) begin
            out_sh_d = mem_rdata;
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = '0;
          end else begin
            out_sh_d = {out_sh_q[DATA_W-2:0], 1'b0};
            cnt_d    = cnt_q + 1'b1;
          end
          if (cnt_q == DATA_PREV) begin
            mem_re   = 1'b1;
            mem_addr = rd_ptr_q;
          end
        end
        default: ;
      endcase
    end
  end

  spi_ram_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we & rst_n),
    .re_i    (mem_re & rst_n),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign spi.MISO      = out_sh_q[DATA_W-1];
  assign spi.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench: two instances (8/8 and 4/16) driven by directed and random SPI frames against
// a word-level RAM/pointer model; a bus monitor reassembles MISO words and checks frame_err.
module tb_spi_ram_burst;

  localparam logic [1:0] C_WA = spi_ram_pkg::CMD_WR_ADDR;
  localparam logic [1:0] C_WD = spi_ram_pkg::CMD_WR_DATA;
  localparam logic [1:0] C_RA = spi_ram_pkg::CMD_RD_ADDR;
  localparam logic [1:0] C_RD = spi_ram_pkg::CMD_RD_DATA;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_ram_burst_if bus8 ();
  spi_ram_burst_if bus4 ();

  spi_ram_burst #(.ADDR_W(8), .DATA_W(8))  dut8 (.clk(clk), .rst_n(rst_n), .spi(bus8));
  spi_ram_burst #(.ADDR_W(4), .DATA_W(16)) dut4 (.clk(clk), .rst_n(rst_n), .spi(bus4));

  typedef struct {
    int          d;
    logic [15:0] w;
  } exp_t;

  int          tests_run;
  int          tests_failed;
  exp_t        expq[$];
  logic [15:0] mem_m [2][256];
  int          wp[2];
  int          rp[2];
  logic        tx_bits[$];

  function automatic int aw_of(input int d);
    return (d != 0) ? 4 : 8;
  endfunction

  function automatic int dw_of(input int d);
    return (d != 0) ? 16 : 8;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic ss, input logic mosi);
    if (d != 0) begin
      bus4.SS_n = ss;
      bus4.MOSI = mosi;
    end else begin
      bus8.SS_n = ss;
      bus8.MOSI = mosi;
    end
  endtask

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_bits.push_back(v[i]);
  endtask

  task automatic rand_bits(input int n);
    for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  // Updates the model for one frame, queues the words a reader must see, then drives the pins.
  task automatic run(input int d, input logic [1:0] cmd, input int reset_at);
    int n, aw, dw, depth, eff;
    logic [15:0] w;
    n = tx_bits.size();
    aw = aw_of(d);
    dw = dw_of(d);
    depth = 1 << aw;
    if (cmd == C_WA || cmd == C_RA) begin
      if (n >= aw) begin
        w = '0;
        for (int i = 0; i < aw; i++) w = {w[14:0], tx_bits[i]};
        if (cmd == C_WA) wp[d] = int'(w);
        else rp[d] = int'(w);
      end
    end else if (cmd == C_WD) begin
      for (int j = 0; j < n / dw; j++) begin
        w = '0;
        for (int i = 0; i < dw; i++) w = {w[14:0], tx_bits[j*dw+i]};
        mem_m[d][wp[d]] = w;
        wp[d] = (wp[d] + 1) % depth;
      end
    end else begin
      eff = (reset_at >= 0) ? reset_at : n;
      for (int j = 0; j < eff / dw; j++) expq.push_back('{d, mem_m[d][(rp[d] + j) % depth]});
      rp[d] = (rp[d] + (eff + dw - 1) / dw) % depth;
    end
    if (reset_at >= 0) begin
      wp = '{0, 0};
      rp = '{0, 0};
    end

    @(negedge clk) drive(d, 1'b0, 1'b0);
    @(negedge clk) drive(d, 1'b0, cmd[1]);
    @(negedge clk) drive(d, 1'b0, cmd[0]);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == reset_at) begin
        rst_n = 1'b0;
        drive(d, 1'b1, 1'b0);
        break;
      end
      drive(d, 1'b0, tx_bits[k]);
    end
    @(negedge clk);
    if (reset_at >= 0) rst_n = 1'b1;
    else drive(d, 1'b1, 1'b0);
    @(negedge clk);
    tx_bits.delete();
  endtask

  // Bus monitor state
  int          m_st[2];
  int          m_e[2];
  int          m_nacc[2];
  logic [1:0]  m_cmd[2];
  logic [15:0] m_acc[2];
  logic        m_err[2];
  bit          m_armed;
  int          m_bits;
  logic        m_ss, m_mosi, m_miso, m_ferr;
  exp_t        m_x;

  initial begin
    m_armed = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_e[d] = 0; m_nacc[d] = 0; m_cmd[d] = '0; m_acc[d] = '0; m_err[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        m_ss   = (d != 0) ? bus4.SS_n : bus8.SS_n;
        m_mosi = (d != 0) ? bus4.MOSI : bus8.MOSI;
        m_err[d] = 1'b0;
        if (!rst_n) begin
          m_st[d] = 0; m_nacc[d] = 0; m_acc[d] = '0;
          m_armed = 1'b1;
        end else if (m_st[d] == 0) begin
          if (!m_ss) begin
            m_st[d] = 1; m_e[d] = 0;
          end
        end else if (m_ss) begin
          m_st[d] = 0; m_nacc[d] = 0; m_acc[d] = '0;
          if (m_e[d] >= 2) begin
            m_bits = m_e[d] - 2;
            if (m_cmd[d] == C_WD && (m_bits % dw_of(d)) != 0) m_err[d] = 1'b1;
            if ((m_cmd[d] == C_WA || m_cmd[d] == C_RA) && m_bits > 0 && m_bits < aw_of(d))
              m_err[d] = 1'b1;
          end
        end else begin
          m_e[d]++;
          if (m_e[d] == 1) m_cmd[d][1] = m_mosi;
          else if (m_e[d] == 2) m_cmd[d][0] = m_mosi;
        end
      end
      #1;
      if (m_armed) begin
        for (int d = 0; d < 2; d++) begin
          m_miso = (d != 0) ? bus4.MISO : bus8.MISO;
          m_ferr = (d != 0) ? bus4.frame_err : bus8.frame_err;
          check($sformatf("frame_err dut%0d", d), 16'(m_ferr), 16'(m_err[d]));
          if (m_st[d] == 1 && m_e[d] >= 3 && m_cmd[d] == C_RD) begin
            m_acc[d] = {m_acc[d][14:0], m_miso};
            m_nacc[d]++;
            if (m_nacc[d] == dw_of(d)) begin
              if (expq.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL read_word dut%0d: got %h, expected no word", d, m_acc[d]);
              end else begin
                m_x = expq.pop_front();
                check("read_word_owner", 16'(d), 16'(m_x.d));
                check($sformatf("read_word dut%0d", d), m_acc[d], m_x.w);
              end
              m_nacc[d] = 0;
              m_acc[d] = '0;
            end
          end else begin
            check($sformatf("miso_idle dut%0d", d), 16'(m_miso), 16'h0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, n;
    logic [1:0] cmd;
    tests_run = 0;
    tests_failed = 0;
    wp = '{0, 0};
    rp = '{0, 0};
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill both RAMs so every later read has a known value.
    push_bits(16'h0, 8); run(0, C_WA, -1);
    for (int i = 0; i < 256; i++) push_bits(16'($urandom_range(0, 255)), 8);
    run(0, C_WD, -1);
    push_bits(16'h0, 4); run(1, C_WA, -1);
    for (int i = 0; i < 16; i++) push_bits(16'($urandom_range(0, 65535)), 16);
    run(1, C_WD, -1);

    // Burst write and gapless burst read across the 0xFF -> 0x00 wrap.
    push_bits(16'hFF, 8); run(0, C_WA, -1);
    push_bits(16'hAA, 8); push_bits(16'h55, 8); push_bits(16'h3C, 8); run(0, C_WD, -1);
    push_bits(16'hFF, 8); run(0, C_RA, -1);
    rand_bits(24); run(0, C_RD, -1);

    // Single word at 0x10; the follow-on read shows rd_ptr advanced to 0x11.
    push_bits(16'h10, 8); run(0, C_WA, -1);
    push_bits(16'h5A, 8); run(0, C_WD, -1);
    push_bits(16'h10, 8); run(0, C_RA, -1);
    rand_bits(8); run(0, C_RD, -1);
    rand_bits(8); run(0, C_RD, -1);

    // Aborted write word: no write, wr_ptr unchanged (next full word lands at 0x20).
    push_bits(16'h20, 8); run(0, C_WA, -1);
    rand_bits(5); run(0, C_WD, -1);
    push_bits(16'h20, 8); run(0, C_RA, -1);
    rand_bits(8); run(0, C_RD, -1);
    push_bits(16'hC3, 8); run(0, C_WD, -1);
    push_bits(16'h20, 8); run(0, C_RA, -1);
    rand_bits(8); run(0, C_RD, -1);

    // Aborted address field.
    push_bits(16'h5, 3); run(0, C_RA, -1);

    // Reset mid read burst, then pointers restart at 0 while RAM keeps its data.
    push_bits(16'h40, 8); run(0, C_RA, -1);
    rand_bits(24); run(0, C_RD, 13);
    rand_bits(16); run(0, C_RD, -1);
    push_bits(16'h77, 8); run(0, C_WD, -1);
    rand_bits(8); run(0, C_RD, -1);

    // Address frame with trailing bits held off in HOLD.
    push_bits(16'h81, 8); push_bits(16'hF, 4); run(0, C_RA, -1);
    rand_bits(8); run(0, C_RD, -1);

    // Narrow-address instance: 17-word burst wraps and overwrites address 0.
    push_bits(16'h0, 4); run(1, C_WA, -1);
    for (int i = 0; i < 17; i++) push_bits(16'($urandom_range(0, 65535)), 16);
    run(1, C_WD, -1);
    push_bits(16'h0, 4); run(1, C_RA, -1);
    rand_bits(16); run(1, C_RD, -1);
    push_bits(16'hF, 4); run(1, C_RA, -1);
    rand_bits(40); run(1, C_RD, -1);

    // Random frames of every kind, including partial fields and mid-word read ends.
    for (int t = 0; t < 40; t++) begin
      d = $urandom_range(0, 1);
      cmd = 2'($urandom_range(0, 3));
      if (cmd == C_WA || cmd == C_RA) begin
        if ($urandom_range(0, 3) == 0) n = $urandom_range(1, aw_of(d) - 1);
        else n = aw_of(d) + $urandom_range(0, 3);
      end else if (cmd == C_WD) begin
        n = $urandom_range(1, 3) * dw_of(d);
        if ($urandom_range(0, 3) == 0) n += $urandom_range(1, dw_of(d) - 1);
      end else begin
        n = $urandom_range(1, 3) * dw_of(d) + $urandom_range(0, dw_of(d) - 1);
      end
      rand_bits(n);
      run(d, cmd, -1);
    end

    repeat (5) @(negedge clk);
    check("expected_words_drained", 16'(expq.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
